// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioner: per-key FSM state encoding and
// an elaboration-time parameter guard.
`ifndef KEY_CONDITIONER_PKG_SV
`define KEY_CONDITIONER_PKG_SV

// Expands to a generate block that stops elaboration when cond is false.
`define KC_PARAM_CHECK(label, cond) \
  if (!(cond)) begin : label \
    $error("key_conditioner: illegal parameter combination"); \
  end

package key_conditioner_pkg;
  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_DELAY  = 2'd1;
  localparam logic [ST_W-1:0] ST_REPEAT = 2'd2;
endpackage

`endif

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, tick-sampled debounce shifter, press/release/repeat FSM.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | key released (level 0), waiting for a stable-high window
// ST_DELAY   | key held (level 1), counting towards the first auto-repeat
// ST_REPEAT  | key held (level 1), emitting a press every REPEAT_RATE ticks
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int DEB_DEPTH    = 4,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int CNT_WIDTH    = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RATE_LAST  = CNT_WIDTH'(REPEAT_RATE - 1);

  logic [1:0]           sync_q;
  logic [DEB_DEPTH-1:0] sh_q, sh_nxt;
  logic [ST_W-1:0]      state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 stable_hi, stable_lo;

  // The FSM judges the window that includes this tick's sample, so the pulse
  // lands in the same edge as the shift that completes the window.
  assign sh_nxt    = {sh_q[DEB_DEPTH-2:0], sync_q[1]};
  assign stable_hi = &sh_nxt;
  assign stable_lo = ~|sh_nxt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick_i) begin
      case (state_q)
        ST_IDLE: begin
          if (stable_hi) begin
            state_d = ST_DELAY;
            level_d = 1'b1;
            press_d = 1'b1;
            cnt_d   = '0;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (stable_lo) begin
            state_d   = ST_IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
            cnt_d     = '0;
          end else if (state_q == ST_REPEAT) begin
            if (cnt_q == RATE_LAST) begin
              press_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end else if (REPEAT_EN != 0) begin
            if (cnt_q == DELAY_LAST) begin
              state_d = ST_REPEAT;
              press_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      sh_q      <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw_i};
      if (tick_i) sh_q <= sh_nxt;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: derives a one-cycle sample tick from the divided
// sample clock and runs one debounce/repeat channel per key.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int NUM_KEYS     = 5,
  parameter int DEB_DEPTH    = 4,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_press
);

  `KC_PARAM_CHECK(g_chk_deb, DEB_DEPTH >= 2)
  `KC_PARAM_CHECK(g_chk_delay, (REPEAT_DELAY >= 1) && (REPEAT_DELAY < (1 << CNT_WIDTH)))
  `KC_PARAM_CHECK(g_chk_rate, (REPEAT_RATE >= 1) && (REPEAT_RATE < (1 << CNT_WIDTH)))

  logic sc_q;
  logic tick_q, tick_d;

  assign tick_d = sample_clk & ~sc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sc_q   <= sample_clk;
      tick_q <= tick_d;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_channel #(
      .DEB_DEPTH   (DEB_DEPTH),
      .REPEAT_EN   (REPEAT_EN),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .CNT_WIDTH   (CNT_WIDTH)
    ) u_ch (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .tick_i   (tick_q),
      .raw_i    (key_raw[k]),
      .level_o  (key_level[k]),
      .press_o  (key_press[k]),
      .release_o(key_release[k])
    );
  end

  assign any_press = |key_press;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: one instance with auto-repeat, one without,
// driven by a 20-clk sample clock generated here.
module tb_key_conditioner;

  logic       clk;
  logic       rst_n;
  logic       sample_clk;
  logic [4:0] key_raw;
  logic [4:0] key_level, key_press, key_release;
  logic       any_press;
  logic [4:0] key_level_nr, key_press_nr, key_release_nr;
  logic       any_press_nr;

  key_conditioner #(
    .NUM_KEYS(5), .DEB_DEPTH(4), .REPEAT_EN(1),
    .REPEAT_DELAY(5), .REPEAT_RATE(2), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .any_press(any_press)
  );

  key_conditioner #(
    .NUM_KEYS(5), .DEB_DEPTH(4), .REPEAT_EN(0),
    .REPEAT_DELAY(5), .REPEAT_RATE(2), .CNT_WIDTH(8)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .key_raw(key_raw),
    .key_level(key_level_nr), .key_press(key_press_nr),
    .key_release(key_release_nr), .any_press(any_press_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-tick observations, collected by one_tick.
  logic [4:0] tp, tr, tpn, trn, first_vec;
  int         first_idx, any_cyc, anyn_cyc;
  int         p_cyc [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // One full sample period: 10 clks low then 10 clks high, raw held throughout.
  task automatic one_tick(input logic [4:0] raw);
    key_raw   = raw;
    tp = '0; tr = '0; tpn = '0; trn = '0; first_vec = '0;
    first_idx = 0; any_cyc = 0; anyn_cyc = 0;
    for (int k = 0; k < 5; k++) p_cyc[k] = 0;
    sample_clk = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) sample_clk = 1'b1;
      @(negedge clk);
      if (key_press != 5'b0 && first_vec == 5'b0) begin
        first_vec = key_press;
        first_idx = i - 9;
      end
      tp  |= key_press;
      tr  |= key_release;
      tpn |= key_press_nr;
      trn |= key_release_nr;
      if (any_press)    any_cyc++;
      if (any_press_nr) anyn_cyc++;
      for (int k = 0; k < 5; k++) p_cyc[k] += int'(key_press[k]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tot, rel_tot;
    logic pat [9];
    rst_n = 1'b0; key_raw = '0; sample_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_level",   key_level,   5'b0);
    check("rst_press",   key_press,   5'b0);
    check("rst_release", key_release, 5'b0);
    check("rst_any",     any_press,   1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Key 0: three-tick press never qualifies.
    tot = 0; rel_tot = 0;
    for (int i = 0; i < 3; i++) begin one_tick(5'b00001); tot += p_cyc[0]; end
    for (int i = 0; i < 4; i++) begin one_tick(5'b00000); tot += p_cyc[0]; rel_tot += int'(tr[0]); end
    check("short_press", tot, 0);
    check("short_rel",   rel_tot, 0);
    check("short_level", key_level[0], 1'b0);

    // Key 0: held long enough; press one cycle after the 4th tick.
    tot = 0;
    for (int i = 0; i < 3; i++) begin one_tick(5'b00001); tot += p_cyc[0]; end
    check("hold_pre", tot, 0);
    one_tick(5'b00001);
    check("hold_press_cnt", p_cyc[0], 1);
    check("hold_press_idx", first_idx, 2);
    check("hold_level", key_level[0], 1'b1);
    check("hold_any", any_cyc, 1);
    for (int d = 1; d <= 4; d++) begin
      one_tick(5'b00000);
      check("k0_rel", tr[0], d == 4);
      check("k0_rel_press", tp[0], 1'b0);
    end
    check("k0_level_low", key_level[0], 1'b0);

    // Key 1: bouncing contact.
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      one_tick({3'b000, pat[i], 1'b0});
      check("bounce_press", tp[1], i == 8);
      check("bounce_rel", tr[1], 1'b0);
    end
    check("bounce_pcyc", p_cyc[1], 1);
    for (int d = 1; d <= 4; d++) begin
      one_tick(5'b00000);
      check("k1_rel", tr[1], d == 4);
    end

    // Key 2: auto-repeat, then release on the tick a repeat is due.
    for (int i = 0; i < 4; i++) begin
      one_tick(5'b00100);
      check("k2_accept", tp[2], i == 3);
      check("k2_accept_nr", tpn[2], i == 3);
    end
    check("k2_level_nr", key_level_nr[2], 1'b1);
    for (int d = 1; d <= 13; d++) begin
      one_tick(5'b00100);
      check("k2_repeat", tp[2], (d >= 5) && (d % 2 == 1));
      check("k2_repeat_nr", tpn[2], 1'b0);
    end
    for (int d = 14; d <= 17; d++) begin
      one_tick(5'b00000);
      check("k2_rel_press", tp[2], d == 15);
      check("k2_rel", tr[2], d == 17);
      check("k2_rel_nr", trn[2], d == 17);
    end
    check("k2_level_low", key_level[2], 1'b0);
    for (int i = 0; i < 2; i++) begin
      one_tick(5'b00000);
      check("k2_idle_quiet", {tp[2], tr[2]}, 2'b00);
    end

    // Keys 0 and 3 together.
    for (int i = 0; i < 4; i++) begin
      one_tick(5'b01001);
      check("dual_any", any_cyc, (i == 3) ? 1 : 0);
    end
    check("dual_vec", first_vec, 5'b01001);
    check("dual_any_nr", anyn_cyc, 1);
    for (int d = 1; d <= 4; d++) begin
      one_tick(5'b00000);
      check("dual_rel", tr, (d == 4) ? 5'b01001 : 5'b00000);
    end

    // Stuck sample clock: nothing moves.
    key_raw = 5'b00001; sample_clk = 1'b0; tot = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tot += int'(key_press != 5'b0) + int'(key_release != 5'b0);
    end
    check("stuck_pulses", tot, 0);
    check("stuck_level", key_level, 5'b0);
    key_raw = 5'b00000;

    // Key 4: reset while repeating, with the key still held.
    for (int i = 0; i < 4; i++) begin
      one_tick(5'b10000);
      check("k4_accept", tp[4], i == 3);
    end
    for (int d = 1; d <= 6; d++) begin
      one_tick(5'b10000);
      check("k4_repeat", tp[4], d == 5);
    end
    check("k4_level_pre", key_level[4], 1'b1);
    rst_n = 1'b0; sample_clk = 1'b0;
    #1;
    check("mid_rst_level", key_level, 5'b0);
    check("mid_rst_press", key_press, 5'b0);
    check("mid_rst_any", any_press, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel_tot = 0;
    for (int i = 0; i < 4; i++) begin
      one_tick(5'b10000);
      check("post_rst_press", tp[4], i == 3);
      rel_tot += int'(tr[4]);
    end
    check("post_rst_rel", rel_tot, 0);
    check("post_rst_level", key_level[4], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
